// File: rtl/audio_packet_decoder.sv
// audio_packet_decoder: sink-side HDMI data-island audio decoder.
// Recovers N/CTS from ACR packets (type 0x01) and stereo IEC 60958 samples from
// 2-channel audio sample packets (type 0x02). Checks per-channel parity, tracks
// the 192-frame channel-status block and queues samples in a first-word-fall-through
// FIFO behind a valid/ready handshake.
// Ports:
//   clk_pixel, reset              sole clock, asynchronous active-high reset
//   packet_valid, header, sub     corrected packet strobe, HB2..HB0, SB6..SB0 x4
//   busy                          sample packet scan in progress (input ignored)
//   audio_sample_word, valid_bit,
//   user_data_bit, audio_valid,
//   audio_ready                   FIFO head and handshake ([0]=left, [1]=right)
//   n, cts, acr_update            clock regeneration values and load pulse
//   channel_status_left/right,
//   channel_status_update         published channel-status block and pulse
//   parity_error, overflow,
//   block_error                   one-cycle event pulses
module audio_packet_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CS_BITS    = 40
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    packet_valid,
  input  logic [23:0]             header,
  input  logic [3:0][55:0]        sub,
  output logic                    busy,
  output logic [1:0][23:0]        audio_sample_word,
  output logic [1:0]              valid_bit,
  output logic [1:0]              user_data_bit,
  output logic                    audio_valid,
  input  logic                    audio_ready,
  output logic [19:0]             n,
  output logic [19:0]             cts,
  output logic                    acr_update,
  output logic [CS_BITS-1:0]      channel_status_left,
  output logic [CS_BITS-1:0]      channel_status_right,
  output logic                    channel_status_update,
  output logic                    parity_error,
  output logic                    overflow,
  output logic                    block_error
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned ENTRY_W = 2 * WORD_W + 4;
  localparam int unsigned IDX_W   = 8;
  localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(191);
  localparam logic [7:0] TYPE_ACR   = 8'h01;
  localparam logic [7:0] TYPE_AUDIO = 8'h02;

  typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;

  state_t          state;
  logic [3:0]      present_q;
  logic [3:0]      flat_q;
  logic [3:0]      b_q;
  logic [3:0][55:0] sub_q;

  logic            accept;
  logic            scan_active;
  logic [1:0]      scan_sel;
  logic [55:0]     cur;
  logic            frame_en;
  logic            cur_b;
  logic [WORD_W-1:0] word_l, word_r;
  logic            v_l, u_l, c_l, v_r, u_r, c_r;
  logic            par_fail_l, par_fail_r;
  logic            unused_hdr;

  assign accept     = packet_valid & ~busy;
  assign unused_hdr = ^header[15:13];

  // Packet accept and scan sequencing; ACR values load directly from the inputs.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      present_q  <= '0;
      flat_q     <= '0;
      b_q        <= '0;
      sub_q      <= '0;
      n          <= '0;
      cts        <= '0;
      acr_update <= 1'b0;
    end else begin
      acr_update <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (header[7:0] == TYPE_ACR) begin
              cts        <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
              n          <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
              acr_update <= 1'b1;
            end else if (header[7:0] == TYPE_AUDIO && !header[12]) begin
              present_q <= header[11:8];
              flat_q    <= header[19:16];
              b_q       <= header[23:20];
              sub_q     <= sub;
              state     <= SCAN0;
              busy      <= 1'b1;
            end
          end
        end
        SCAN0: state <= SCAN1;
        SCAN1: state <= SCAN2;
        SCAN2: state <= SCAN3;
        SCAN3: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Select the subpacket owned by the current scan state.
  always_comb begin
    scan_active = 1'b1;
    scan_sel    = 2'd0;
    case (state)
      SCAN0:   scan_sel = 2'd0;
      SCAN1:   scan_sel = 2'd1;
      SCAN2:   scan_sel = 2'd2;
      SCAN3:   scan_sel = 2'd3;
      default: scan_active = 1'b0;
    endcase
  end

  assign cur      = sub_q[scan_sel];
  assign frame_en = scan_active & present_q[scan_sel] & ~flat_q[scan_sel];
  assign cur_b    = b_q[scan_sel];

  assign word_l = cur[23:0];
  assign word_r = cur[47:24];
  assign v_l    = cur[48];
  assign u_l    = cur[49];
  assign c_l    = cur[50];
  assign v_r    = cur[52];
  assign u_r    = cur[53];
  assign c_r    = cur[54];

  // Even parity over P, C, U, V and the word.
  assign par_fail_l = ^{cur[51:48], word_l};
  assign par_fail_r = ^{cur[55:52], word_r};

  // ---------------- sample FIFO ----------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_next;
  logic               fifo_full, pop, push_ok;
  logic [ENTRY_W-1:0] push_entry, head;

  assign push_entry = {u_r, u_l, v_r, v_l, word_r, word_l};
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = audio_valid & audio_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = frame_en & (~fifo_full | pop);

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      audio_valid <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      audio_valid <= (count_next != '0);
    end
  end

  assign head                 = mem[rd_ptr];
  assign audio_sample_word[0] = head[23:0];
  assign audio_sample_word[1] = head[47:24];
  assign valid_bit            = head[49:48];
  assign user_data_bit        = head[51:50];

  // ---------------- channel-status tracking ----------------
  logic [IDX_W-1:0]   cs_idx, cs_idx_next, cs_pos;
  logic               cs_synced, cs_synced_next;
  logic               cs_err, cs_capture, cs_publish;
  logic [CS_BITS-1:0] shadow_l, shadow_r, shadow_l_next, shadow_r_next;

  // cs_idx holds the index expected for the next frame; a wrap to 0 means the
  // block just completed, so a frame without B there is a lost block start.
  always_comb begin
    cs_idx_next    = cs_idx;
    cs_synced_next = cs_synced;
    cs_err         = 1'b0;
    cs_capture     = 1'b0;
    cs_publish     = 1'b0;
    cs_pos         = cs_idx;
    if (frame_en) begin
      if (cur_b) begin
        cs_err         = cs_synced && (cs_idx != '0);
        cs_synced_next = 1'b1;
        cs_capture     = 1'b1;
        cs_pos         = '0;
        cs_idx_next    = IDX_W'(1);
      end else if (cs_synced) begin
        if (cs_idx == '0) begin
          cs_err         = 1'b1;
          cs_synced_next = 1'b0;
        end else begin
          cs_capture  = 1'b1;
          cs_publish  = (cs_idx == LAST_FRAME);
          cs_idx_next = cs_publish ? '0 : cs_idx + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    shadow_l_next = shadow_l;
    shadow_r_next = shadow_r;
    if (cs_capture) begin
      for (int k = 0; k < int'(CS_BITS); k++) begin
        if (cs_pos == IDX_W'(k)) begin
          shadow_l_next[k] = c_l;
          shadow_r_next[k] = c_r;
        end
      end
    end
  end

  // Tracking state, published status and event pulses.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cs_idx                <= '0;
      cs_synced             <= 1'b0;
      shadow_l              <= '0;
      shadow_r              <= '0;
      channel_status_left   <= '0;
      channel_status_right  <= '0;
      channel_status_update <= 1'b0;
      parity_error          <= 1'b0;
      overflow              <= 1'b0;
      block_error           <= 1'b0;
    end else begin
      cs_idx                <= cs_idx_next;
      cs_synced             <= cs_synced_next;
      shadow_l              <= shadow_l_next;
      shadow_r              <= shadow_r_next;
      channel_status_update <= cs_publish;
      if (cs_publish) begin
        channel_status_left  <= shadow_l_next;
        channel_status_right <= shadow_r_next;
      end
      parity_error <= frame_en & (par_fail_l | par_fail_r);
      overflow     <= frame_en & ~push_ok;
      block_error  <= cs_err;
    end
  end

endmodule
